instruction_cache: RTL and testbench

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

---
 rtl/instruction_cache_pkg.sv | 15 +
 rtl/instruction_cache.sv | 159 +++++++++++++++
 tb/tb_instruction_cache.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// controller state encoding and geometry defaults.
package instruction_cache_pkg;

    localparam int INDEX_W_DEF    = 7;
    localparam int LINE_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DONE
    } state_e;

endpackage

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache, one word per line, refilled
// byte-serially from a shared RAM port after an arbiter grant.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int INDEX_W    = INDEX_W_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_start,
    input  logic [31:0] pc_in,
    input  logic        roll_back_in,
    output logic        finish_fetch,
    output logic [31:0] instruction_out,
    output logic [31:0] instruction_pc_out,
    output logic        is_idle,
    output logic        ram_req,
    input  logic        ram_grant,
    output logic [31:0] ram_addr_out,
    input  logic [7:0]  ram_data_in
);

    localparam int         LINES = 1 << INDEX_W;
    localparam int         TAG_W = 30 - INDEX_W;
    localparam logic [1:0] LAST  = 2'(LINE_BYTES - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [29:0]       pc_q, pc_d;
    logic [23:0]       buf_q, buf_d;
    logic [31:0]       addr_q, addr_d;
    logic              fin_q, fin_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       ipc_q, ipc_d;
    logic [LINES-1:0]  valid_q, valid_d;

    logic [TAG_W-1:0]  tag_mem [LINES];
    logic [31:0]       data_mem [LINES];

    logic [INDEX_W-1:0] idx_in, fill_idx;
    logic [TAG_W-1:0]   tag_in, fill_tag;
    logic               hit;
    logic               we;
    logic [31:0]        line_word;
    logic               unused_pc;

    assign idx_in    = pc_in[INDEX_W+1:2];
    assign tag_in    = pc_in[31:INDEX_W+2];
    assign fill_idx  = pc_q[INDEX_W-1:0];
    assign fill_tag  = pc_q[29:INDEX_W];
    assign hit       = valid_q[idx_in] && (tag_mem[idx_in] == tag_in);
    assign line_word = {ram_data_in, buf_q};
    assign unused_pc = ^pc_in[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        fin_d   = fin_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        we      = 1'b0;
        // Flush wins over everything, including a pause.
        if (roll_back_in) begin
            state_d = IDLE;
            fin_d   = 1'b0;
            cnt_d   = 2'd0;
        end else if (rdy_in) begin
            fin_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (fetch_start) begin
                        if (hit) begin
                            fin_d   = 1'b1;
                            instr_d = data_mem[idx_in];
                            ipc_d   = {pc_in[31:2], 2'b00};
                        end else begin
                            pc_d    = pc_in[31:2];
                            state_d = REQ;
                        end
                    end
                end
                REQ: begin
                    if (ram_grant) begin
                        addr_d  = {pc_q, 2'b00};
                        cnt_d   = 2'd0;
                        state_d = FILL;
                    end
                end
                FILL: begin
                    if (cnt_q == LAST) begin
                        we                = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                        fin_d             = 1'b1;
                        instr_d           = line_word;
                        ipc_d             = {pc_q, 2'b00};
                        state_d           = DONE;
                    end else begin
                        buf_d[{cnt_q, 3'b000} +: 8] = ram_data_in;
                        cnt_d  = cnt_q + 2'd1;
                        addr_d = {pc_q, cnt_q + 2'd1};
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            pc_q    <= 30'd0;
            buf_q   <= 24'd0;
            addr_q  <= 32'd0;
            fin_q   <= 1'b0;
            instr_q <= 32'd0;
            ipc_q   <= 32'd0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            fin_q   <= fin_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= line_word;
        end
    end

    // The address is issued combinationally so +0 leaves in the grant cycle.
    assign ram_addr_out       = addr_d;
    assign ram_req            = (state_q == REQ) ||
                                ((state_q == FILL) && (cnt_q != LAST));
    assign finish_fetch       = fin_q && rdy_in && !roll_back_in;
    assign instruction_out    = instr_q;
    assign instruction_pc_out = ipc_q;
    assign is_idle            = (state_q == IDLE) && !fin_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios plus
// random traffic against a transaction-level cache/RAM model.
module tb_instruction_cache;
    import instruction_cache_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        fetch_start = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        roll_back_in = 1'b0;
    logic        finish_fetch;
    logic [31:0] instruction_out;
    logic [31:0] instruction_pc_out;
    logic        is_idle;
    logic        ram_req;
    logic        ram_grant = 1'b0;
    logic [31:0] ram_addr_out;
    logic [7:0]  ram_data_in = 8'd0;

    instruction_cache dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .fetch_start(fetch_start),
        .pc_in(pc_in),
        .roll_back_in(roll_back_in),
        .finish_fetch(finish_fetch),
        .instruction_out(instruction_out),
        .instruction_pc_out(instruction_pc_out),
        .is_idle(is_idle),
        .ram_req(ram_req),
        .ram_grant(ram_grant),
        .ram_addr_out(ram_addr_out),
        .ram_data_in(ram_data_in)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Arbiter protocol: grant must stay up while a burst is in flight.
    always @(negedge clk_in) begin
        if (!rst_in && dut.state_q == FILL && ram_req)
            assert (ram_grant) else $error("FAIL grant_drop mid-fill");
    end

    // RAM contents: explicit bytes, otherwise an address hash.
    logic [7:0] ram_init [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_init.exists(a)) return ram_init[a];
        return 8'((a * 32'h9d) + (a >> 8) + 32'h31);
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] b);
        return {ram_rd(b + 3), ram_rd(b + 2), ram_rd(b + 1), ram_rd(b)};
    endfunction

    // Reference model: cache contents keyed by index, plus transaction phase.
    logic [31:0] m_addr [int];
    logic [31:0] m_data [int];
    int          m_phase;
    int          m_fill;
    logic [31:0] m_base;
    bit          m_res;
    logic [31:0] m_res_ins;
    logic [31:0] m_res_pc;

    int          gwait;
    int          gdelay = 0;
    logic [31:0] prev_addr;

    logic        s_fin, s_req, s_idle;
    logic [31:0] s_addr, s_ins, s_pc;

    task automatic model_reset();
        m_addr.delete();
        m_data.delete();
        m_phase   = 0;
        m_fill    = 0;
        m_res     = 0;
        prev_addr = 32'd0;
        ram_grant = 1'b0;
        gwait     = 0;
    endtask

    task automatic model_cycle();
        bit          exp_fin;
        logic [31:0] exp_addr;
        logic [31:0] pa;
        logic [31:0] w;
        int          idx;
        exp_fin = m_res && rdy_in && !roll_back_in;
        check("finish_fetch", 32'(s_fin), 32'(exp_fin));
        if (exp_fin) begin
            check("instr", s_ins, m_res_ins);
            check("instr_pc", s_pc, m_res_pc);
        end
        check("is_idle", 32'(s_idle), 32'(m_phase == 0 && !m_res));
        check("ram_req", 32'(s_req),
              32'(m_phase == 1 || (m_phase == 2 && m_fill < 3)));
        exp_addr = prev_addr;
        if (rdy_in && !roll_back_in) begin
            if (m_phase == 1 && ram_grant)
                exp_addr = m_base;
            else if (m_phase == 2 && m_fill < 3)
                exp_addr = m_base + 32'(m_fill + 1);
        end
        check("ram_addr", s_addr, exp_addr);
        if (roll_back_in) begin
            m_phase = 0;
            m_res   = 0;
        end else if (rdy_in) begin
            m_res = 0;
            case (m_phase)
                0: if (fetch_start) begin
                    pa  = {pc_in[31:2], 2'b00};
                    idx = int'(pa[8:2]);
                    if (m_addr.exists(idx) && m_addr[idx] == pa) begin
                        m_res     = 1;
                        m_res_ins = m_data[idx];
                        m_res_pc  = pa;
                    end else begin
                        m_phase = 1;
                        m_base  = pa;
                    end
                end
                1: if (ram_grant) begin
                    m_phase = 2;
                    m_fill  = 0;
                end
                2: if (m_fill == 3) begin
                    w           = ram_word(m_base);
                    idx         = int'(m_base[8:2]);
                    m_addr[idx] = m_base;
                    m_data[idx] = w;
                    m_res       = 1;
                    m_res_ins   = w;
                    m_res_pc    = m_base;
                    m_phase     = 3;
                end else begin
                    m_fill++;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    // Called at posedge+1 with inputs set; samples at the falling edge.
    task automatic step();
        if (!ram_req) begin
            ram_grant = 1'b0;
            gwait     = 0;
        end else if (!ram_grant) begin
            if (gwait >= gdelay) ram_grant = 1'b1;
            else gwait++;
        end
        ram_data_in = ram_rd(prev_addr);
        #4;
        s_fin  = finish_fetch;
        s_req  = ram_req;
        s_idle = is_idle;
        s_addr = ram_addr_out;
        s_ins  = instruction_out;
        s_pc   = instruction_pc_out;
        model_cycle();
        prev_addr = ram_addr_out;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_finish"}, 32'(finish_fetch), 32'd0);
        check({tag, "_req"}, 32'(ram_req), 32'd0);
        check({tag, "_addr"}, ram_addr_out, 32'd0);
        check({tag, "_instr"}, instruction_out, 32'd0);
        check({tag, "_ipc"}, instruction_pc_out, 32'd0);
        check({tag, "_idle"}, 32'(is_idle), 32'd1);
    endtask

    task automatic run_fetch(input logic [31:0] pc, input int pause_at,
                             input int rb_at, input int limit,
                             output int lat, output logic [31:0] ins,
                             output logic [31:0] ipc, output bit saw_req,
                             output bit rb_req, output bit rb_idle);
        lat     = -1;
        ins     = 32'd0;
        ipc     = 32'd0;
        saw_req = 0;
        rb_req  = 1;
        rb_idle = 0;
        fetch_start = 1'b1;
        pc_in       = pc;
        step();
        fetch_start = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            rdy_in       = !(i == pause_at || i == pause_at + 1);
            roll_back_in = (i == rb_at);
            step();
            saw_req |= s_req;
            if (i == rb_at + 1) begin
                rb_req  = s_req;
                rb_idle = s_idle;
            end
            if (s_fin && lat < 0) begin
                lat = i;
                ins = s_ins;
                ipc = s_pc;
            end
            if (lat >= 0 && rb_at < 0) break;
        end
        rdy_in       = 1'b1;
        roll_back_in = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] ins, ipc;
        bit          sreq, rbq, rbi;

        ram_init[32'h4] = 8'h13;
        ram_init[32'h5] = 8'h05;
        ram_init[32'h6] = 8'h10;
        ram_init[32'h7] = 8'h00;

        #1 rst_in = 1'b1;
        #11;
        check_reset_outputs("reset");
        model_reset();
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        run_fetch(32'h4, -10, -10, 20, lat, ins, ipc, sreq, rbq, rbi);
        check("cold_lat", lat, 32'd6);
        check("cold_instr", ins, 32'h0010_0513);
        check("cold_pc", ipc, 32'h4);

        run_fetch(32'h4, -10, -10, 20, lat, ins, ipc, sreq, rbq, rbi);
        check("hit_lat", lat, 32'd1);
        check("hit_instr", ins, 32'h0010_0513);
        check("hit_no_req", 32'(sreq), 32'd0);

        run_fetch(32'h204, -10, -10, 20, lat, ins, ipc, sreq, rbq, rbi);
        check("conflict_lat", lat, 32'd6);
        check("conflict_instr", ins, ram_word(32'h204));
        check("conflict_pc", ipc, 32'h204);
        run_fetch(32'h4, -10, -10, 20, lat, ins, ipc, sreq, rbq, rbi);
        check("evicted_lat", lat, 32'd6);
        check("evicted_instr", ins, 32'h0010_0513);

        gdelay = 3;
        run_fetch(32'h8, -10, -10, 30, lat, ins, ipc, sreq, rbq, rbi);
        check("late_grant_lat", lat, 32'd9);
        check("late_grant_instr", ins, ram_word(32'h8));
        gdelay = 0;

        run_fetch(32'hC, -10, 4, 12, lat, ins, ipc, sreq, rbq, rbi);
        check("rollback_no_finish", lat, 32'hFFFF_FFFF);
        check("rollback_req", 32'(rbq), 32'd0);
        check("rollback_idle", 32'(rbi), 32'd1);
        run_fetch(32'hC, -10, -10, 20, lat, ins, ipc, sreq, rbq, rbi);
        check("rollback_refetch_lat", lat, 32'd6);

        run_fetch(32'h10, 3, -10, 20, lat, ins, ipc, sreq, rbq, rbi);
        check("pause_lat", lat, 32'd8);
        check("pause_instr", ins, ram_word(32'h10));

        fetch_start = 1'b1;
        pc_in       = 32'h14;
        step();
        fetch_start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst_in = 1'b1;
        #2;
        check_reset_outputs("midfill_reset");
        model_reset();
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        for (int i = 0; i < 10; i++) step();
        run_fetch(32'h14, -10, -10, 20, lat, ins, ipc, sreq, rbq, rbi);
        check("post_reset_lat", lat, 32'd6);
        run_fetch(32'h4, -10, -10, 20, lat, ins, ipc, sreq, rbq, rbi);
        check("post_reset_cleared", lat, 32'd6);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pr;
            rdy_in       = ($urandom_range(0, 9) != 0);
            roll_back_in = ($urandom_range(0, 39) == 0);
            fetch_start  = ($urandom_range(0, 2) == 0);
            pr = (32'($urandom_range(0, 3)) << 9) |
                 (32'($urandom_range(0, 7)) << 2) |
                 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) pr = pr | 32'hFFFF_0000;
            pc_in = pr;
            if (!ram_req) gdelay = $urandom_range(0, 2);
            step();
        end
        rdy_in       = 1'b1;
        roll_back_in = 1'b0;
        fetch_start  = 1'b0;
        gdelay       = 0;
        for (int i = 0; i < 20; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
